// File: rtl/wino_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wino_io_pkg
//  Description : Shared types and helpers for the Winograd I/O serdes:
//                FSM state encoding, beat-count helpers, counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package wino_io_pkg;

    // Top-level sequencing states of the serdes
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Pin-bus beats needed to carry one input tile
    function automatic int in_beats(input int in_n, input int data_w, input int pin_w);
        return (in_n * data_w) / pin_w;
    endfunction

    // Pin-bus beats needed to carry one output tile
    function automatic int out_beats(input int out_n, input int data_w, input int pin_w);
        return (out_n * data_w) / pin_w;
    endfunction

    // Width of a counter holding 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter widths for the default F(4,3) configuration
    localparam int c_def_in_beat_w  = $clog2(6);
    localparam int c_def_out_beat_w = $clog2(4);
    localparam int c_def_lat_w      = $clog2(2);

endpackage : wino_io_pkg
`default_nettype wire

// File: rtl/wino_io_shift.sv
`default_nettype none
// ============================================================================
//  Module      : wino_io_shift
//  Description : W-bit register with parallel load plus PIN_W-wide slice
//                write and slice read, both selected by a slice index.
//  Revision    : 1.0 - initial release
// ============================================================================
module wino_io_shift #(
    parameter int W     = 60,
    parameter int PIN_W = 10,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [W-1:0]     load_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PIN_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PIN_W-1:0] rd_data,
    output logic [W-1:0]     q
);

    localparam int c_slices = W / PIN_W;

    logic [W-1:0] data_q;

    // Storage: parallel load wins over a slice write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_en) begin
            data_q <= load_data;
        end else if (wr_en) begin
            for (int s = 0; s < c_slices; s++) begin
                if (wr_idx == IDX_W'(s)) begin
                    data_q[s*PIN_W +: PIN_W] <= wr_data;
                end
            end
        end
    end

    // Slice read mux
    always_comb begin
        rd_data = '0;
        for (int s = 0; s < c_slices; s++) begin
            if (rd_idx == IDX_W'(s)) begin
                rd_data = data_q[s*PIN_W +: PIN_W];
            end
        end
    end

    assign q = data_q;

endmodule : wino_io_shift
`default_nettype wire

// File: rtl/wino_io_serdes.sv
`default_nettype none
// ============================================================================
//  Module      : wino_io_serdes
//  Description : Pin-efficient front end for the Winograd conv core.
//                Deserialises PIN_W-bit beats into a tile for the core,
//                waits the fixed core latency, then serialises the result
//                back out with valid/ready. LSB beat first.
//                Optional: IO_LOOPBACK_EN adds cfg_loopback, which routes the
//                low OUT_N words of the input tile back out instead of core_Z.
//  Revision    : 1.0 - initial release
// ============================================================================
module wino_io_serdes
    import wino_io_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int IN_N     = 6,
    parameter int OUT_N    = 4,
    parameter int PIN_W    = 10,
    parameter int CORE_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef IO_LOOPBACK_EN
    input  logic                    cfg_loopback,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIN_W-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIN_W-1:0]        out_data,
    output logic                    out_last,
    output logic                    core_start,
    output logic [IN_N*DATA_W-1:0]  core_D,
    input  logic [OUT_N*DATA_W-1:0] core_Z,
    output logic                    busy
);

    localparam int c_dw    = IN_N * DATA_W;
    localparam int c_zw    = OUT_N * DATA_W;
    localparam int c_ib    = in_beats(IN_N, DATA_W, PIN_W);
    localparam int c_ob    = out_beats(OUT_N, DATA_W, PIN_W);
    localparam int c_ib_w  = cnt_w(c_ib);
    localparam int c_ob_w  = cnt_w(c_ob);
    localparam int c_lat_w = cnt_w(CORE_LAT);

    // Reject configurations the beat slicing cannot represent
    if (((IN_N * DATA_W) % PIN_W != 0) || ((OUT_N * DATA_W) % PIN_W != 0)) begin : g_bad_pin_w
        $fatal(1, "wino_io_serdes: PIN_W must divide IN_N*DATA_W and OUT_N*DATA_W");
    end
    if (CORE_LAT < 1) begin : g_bad_core_lat
        $fatal(1, "wino_io_serdes: CORE_LAT must be >= 1");
    end

    state_t              state_q, state_d;
    logic [c_ib_w-1:0]   ibeat_q, ibeat_d;
    logic [c_ob_w-1:0]   obeat_q, obeat_d;
    logic [c_lat_w-1:0]  lat_q, lat_d;

    logic                w_in_fire;
    logic                w_in_last;
    logic                w_out_fire;
    logic                w_out_last_beat;
    logic                w_zload;
    logic [c_zw-1:0]     w_zsrc;
    logic [c_dw-1:0]     w_tile_q;
    logic [PIN_W-1:0]    w_zbuf_rd;
    logic [PIN_W-1:0]    w_unused_tile_rd;
    logic [c_zw-1:0]     w_unused_zbuf_q;

    assign w_in_fire       = (state_q == ST_COLLECT) && in_valid;
    assign w_in_last       = (ibeat_q == c_ib_w'(c_ib - 1));
    assign w_out_fire      = (state_q == ST_DRAIN) && out_ready;
    assign w_out_last_beat = (obeat_q == c_ob_w'(c_ob - 1));
    assign w_zload         = (state_q == ST_WAIT) && (lat_q == c_lat_w'(CORE_LAT - 1));

    // Input tile: beat k lands in slice k, held until the next COLLECT overwrites it
    wino_io_shift #(
        .W     (c_dw),
        .PIN_W (PIN_W),
        .IDX_W (c_ib_w)
    ) u_tile (
        .clk       (clk),
        .rst       (rst),
        .load_en   (1'b0),
        .load_data ({c_dw{1'b0}}),
        .wr_en     (w_in_fire),
        .wr_idx    (ibeat_q),
        .wr_data   (in_data),
        .rd_idx    ({c_ib_w{1'b0}}),
        .rd_data   (w_unused_tile_rd),
        .q         (w_tile_q)
    );

    // Result buffer: loaded once at WAIT exit, read out slice by slice in DRAIN
    wino_io_shift #(
        .W     (c_zw),
        .PIN_W (PIN_W),
        .IDX_W (c_ob_w)
    ) u_zbuf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (w_zload),
        .load_data (w_zsrc),
        .wr_en     (1'b0),
        .wr_idx    ({c_ob_w{1'b0}}),
        .wr_data   ({PIN_W{1'b0}}),
        .rd_idx    (obeat_q),
        .rd_data   (w_zbuf_rd),
        .q         (w_unused_zbuf_q)
    );

`ifdef IO_LOOPBACK_EN
    logic loopback_q;

    // Loopback select is latched at ISSUE so it stays fixed for the whole tile
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loopback_q <= 1'b0;
        end else if (state_q == ST_ISSUE) begin
            loopback_q <= cfg_loopback;
        end
    end

    assign w_zsrc = loopback_q ? w_tile_q[c_zw-1:0] : core_Z;
`else
    assign w_zsrc = core_Z;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (w_in_fire && w_in_last)        state_d = ST_ISSUE;
            ST_ISSUE:                                      state_d = ST_WAIT;
            ST_WAIT:    if (w_zload)                       state_d = ST_DRAIN;
            ST_DRAIN:   if (w_out_fire && w_out_last_beat) state_d = ST_COLLECT;
            default:                                       state_d = ST_COLLECT;
        endcase
    end

    // FSM outputs; out_data is zero outside DRAIN
    always_comb begin
        in_ready   = (state_q == ST_COLLECT);
        core_start = (state_q == ST_ISSUE);
        out_valid  = (state_q == ST_DRAIN);
        busy       = (state_q != ST_COLLECT);
        out_last   = (state_q == ST_DRAIN) && w_out_last_beat;
        out_data   = (state_q == ST_DRAIN) ? w_zbuf_rd : '0;
    end

    // Counter next values: input beat, core latency, output beat
    always_comb begin
        ibeat_d = ibeat_q;
        obeat_d = obeat_q;
        lat_d   = lat_q;
        case (state_q)
            ST_COLLECT: if (w_in_fire)  ibeat_d = w_in_last ? '0 : ibeat_q + 1'b1;
            ST_ISSUE:                   lat_d   = '0;
            ST_WAIT:    if (!w_zload)   lat_d   = lat_q + 1'b1;
            ST_DRAIN:   if (w_out_fire) obeat_d = w_out_last_beat ? '0 : obeat_q + 1'b1;
            default: ;
        endcase
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibeat_q <= '0;
            obeat_q <= '0;
            lat_q   <= '0;
        end else begin
            ibeat_q <= ibeat_d;
            obeat_q <= obeat_d;
            lat_q   <= lat_d;
        end
    end

    assign core_D = w_tile_q;

endmodule : wino_io_serdes
`default_nettype wire
